// File: rtl/dbus_if.sv
`default_nettype none
// ============================================================================
// Module   : dbus_if
// Brief    : Data-side memory port between the memory-access stage and a slave.
// Revision : 1.0
// ============================================================================
interface dbus_if;
    logic        dbus_en;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_wen;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_stall;
    logic        dbus_err;

    modport master (
        output dbus_en, dbus_addr, dbus_wen, dbus_wdata,
        input  dbus_rdata, dbus_stall, dbus_err
    );

    modport slave (
        input  dbus_en, dbus_addr, dbus_wen, dbus_wdata,
        output dbus_rdata, dbus_stall, dbus_err
    );
endinterface
`default_nettype wire

// File: rtl/dbus_responder.sv
`default_nettype none
// ============================================================================
// Module   : dbus_responder
// Brief    : Word-organised data RAM slave with byte-lane writes, programmable
//            wait states, stall generation and out-of-range error flag.
// Revision : 1.0
// ============================================================================
module dbus_responder #(
    parameter int AW          = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    dbus_if.slave     dbus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [3:0]  r_wen;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [0:(1<<AW)-1];

    logic [31:0] w_addr;
    logic [3:0]  w_wen;
    logic [31:0] w_wdata;
    logic [AW-1:0] w_idx;
    logic        w_in_range;
    logic        w_complete;

    // With no wait states the access completes on the acceptance edge, so the
    // live bus values are used there instead of the not-yet-captured copies.
    assign w_addr     = (r_state == S_IDLE) ? dbus.dbus_addr  : r_addr;
    assign w_wen      = (r_state == S_IDLE) ? dbus.dbus_wen   : r_wen;
    assign w_wdata    = (r_state == S_IDLE) ? dbus.dbus_wdata : r_wdata;
    assign w_idx      = w_addr[AW+1:2];
    assign w_in_range = (w_addr[31:AW+2] == '0);
    assign w_complete = !rst && dbus.dbus_en &&
                        (((r_state == S_IDLE) && (WAIT_CYCLES == 0)) ||
                         ((r_state == S_BUSY) && (r_cnt == 4'd0)));

    assign dbus.dbus_stall = dbus.dbus_en && (r_state != S_DONE);
    assign dbus.dbus_rdata = r_rdata;
    assign dbus.dbus_err   = r_err;

    always_ff @(posedge clk) begin
        if (w_complete && w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wen[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wen   <= 4'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_complete) begin
                r_state <= S_DONE;
                if (w_in_range) begin
                    r_rdata <= r_mem[w_idx];
                    r_err   <= 1'b0;
                end else begin
                    r_rdata <= 32'd0;
                    r_err   <= 1'b1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (dbus.dbus_en) begin
                        r_addr  <= dbus.dbus_addr;
                        r_wen   <= dbus.dbus_wen;
                        r_wdata <= dbus.dbus_wdata;
                        if (WAIT_CYCLES != 0) begin
                            r_cnt   <= c_WAIT_LOAD;
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (!dbus.dbus_en) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dbus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbus_responder
// Brief    : Directed self-checking bench for dbus_responder (2 and 0 waits).
// Revision : 1.0
// ============================================================================
module tb_dbus_responder;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   nstall;
    logic [31:0] rdv;
    logic        errv;

    dbus_if b2 ();
    dbus_if b0 ();

    dbus_responder #(.AW(10), .WAIT_CYCLES(2)) u_dut2 (.clk(clk), .rst(rst), .dbus(b2.slave));
    dbus_responder #(.AW(10), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .dbus(b0.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full access on the 2-wait instance; counts stall-high samples, returns DONE outputs.
    task automatic acc2(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                        output int ns, output logic [31:0] rd, output logic e);
        @(negedge clk);
        b2.dbus_en = 1'b1; b2.dbus_addr = a; b2.dbus_wen = w; b2.dbus_wdata = d;
        #1;
        ns = 0;
        while (b2.dbus_stall === 1'b1 && ns < 20) begin
            ns++;
            @(negedge clk);
            #1;
        end
        rd = b2.dbus_rdata;
        e  = b2.dbus_err;
        b2.dbus_en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        b2.dbus_en = 1'b0; b2.dbus_addr = '0; b2.dbus_wen = '0; b2.dbus_wdata = '0;
        b0.dbus_en = 1'b0; b0.dbus_addr = '0; b0.dbus_wen = '0; b0.dbus_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_rdata", b2.dbus_rdata, 32'h0);
        check("reset_err",   32'(b2.dbus_err), 32'h0);
        check("reset_stall", 32'(b2.dbus_stall), 32'h0);

        // Stall follows the request combinationally; withdraw before the edge.
        @(negedge clk);
        b2.dbus_en = 1'b1;
        #1;
        check("stall_same_cycle", 32'(b2.dbus_stall), 32'h1);
        b2.dbus_en = 1'b0;

        acc2(32'h100, 4'b1111, 32'hDEADBEEF, nstall, rdv, errv);
        check("wr100_stalls", 32'(nstall), 32'd3);
        check("wr100_err", 32'(errv), 32'h0);
        acc2(32'h100, 4'b0000, 32'h0, nstall, rdv, errv);
        check("rd100_stalls", 32'(nstall), 32'd3);
        check("rd100_data", rdv, 32'hDEADBEEF);

        acc2(32'h100, 4'b0010, 32'h0000AA00, nstall, rdv, errv);
        check("bytewr_rbw_data", rdv, 32'hDEADBEEF);
        acc2(32'h100, 4'b0000, 32'h0, nstall, rdv, errv);
        check("bytewr_readback", rdv, 32'hDEADAAEF);

        // Abort in the first BUSY cycle.
        acc2(32'h104, 4'b1111, 32'h11111111, nstall, rdv, errv);
        @(negedge clk);
        b2.dbus_en = 1'b1; b2.dbus_addr = 32'h104; b2.dbus_wen = 4'b1111; b2.dbus_wdata = 32'h12345678;
        @(negedge clk);
        b2.dbus_en = 1'b0;
        #1;
        check("abort_stall_low", 32'(b2.dbus_stall), 32'h0);
        check("abort_err_kept", 32'(b2.dbus_err), 32'h0);
        acc2(32'h104, 4'b0000, 32'h0, nstall, rdv, errv);
        check("abort_next_stalls", 32'(nstall), 32'd3);
        check("abort_readback", rdv, 32'h11111111);

        // Out of range.
        acc2(32'h0, 4'b1111, 32'hCAFEF00D, nstall, rdv, errv);
        acc2(32'h1000, 4'b0000, 32'h0, nstall, rdv, errv);
        check("oor_rd_err", 32'(errv), 32'h1);
        check("oor_rd_data", rdv, 32'h0);
        check("oor_rd_stalls", 32'(nstall), 32'd3);
        @(negedge clk);
        #1;
        check("oor_err_one_cycle", 32'(b2.dbus_err), 32'h0);
        acc2(32'h1000, 4'b1111, 32'hFFFFFFFF, nstall, rdv, errv);
        check("oor_wr_err", 32'(errv), 32'h1);
        acc2(32'h0, 4'b0000, 32'h0, nstall, rdv, errv);
        check("oor_word0_intact", rdv, 32'hCAFEF00D);
        check("inrange_err_clear", 32'(errv), 32'h0);

        // Zero wait states, back-to-back with the request held high.
        @(negedge clk);
        b0.dbus_en = 1'b1; b0.dbus_addr = 32'h20; b0.dbus_wen = 4'b1111; b0.dbus_wdata = 32'hA5A5A5A5;
        #1;
        check("w0_wr_stall_hi", 32'(b0.dbus_stall), 32'h1);
        @(negedge clk);
        #1;
        check("w0_wr_stall_lo", 32'(b0.dbus_stall), 32'h0);
        b0.dbus_wen = 4'b0000;
        @(negedge clk);
        #1;
        check("w0_rd_stall_hi", 32'(b0.dbus_stall), 32'h1);
        @(negedge clk);
        #1;
        check("w0_rd_stall_lo", 32'(b0.dbus_stall), 32'h0);
        check("w0_rd_data", b0.dbus_rdata, 32'hA5A5A5A5);
        check("w0_rd_err", 32'(b0.dbus_err), 32'h0);
        b0.dbus_wen = 4'b1111; b0.dbus_wdata = 32'h5A5A5A5A;
        @(negedge clk);
        #1;
        check("w0_rst_accept_stall", 32'(b0.dbus_stall), 32'h1);
        rst = 1'b1;
        #1;
        check("w0_rst_rdata", b0.dbus_rdata, 32'h0);
        check("w0_rst_err", 32'(b0.dbus_err), 32'h0);
        b0.dbus_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        b0.dbus_en = 1'b1; b0.dbus_wen = 4'b0000;
        #1;
        check("w0_post_rst_stall", 32'(b0.dbus_stall), 32'h1);
        @(negedge clk);
        #1;
        check("w0_no_write_data", b0.dbus_rdata, 32'hA5A5A5A5);
        b0.dbus_en = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
